// File: rtl/aes128_dec_iter.sv
// aes128_dec_iter: iterative AES-128 inverse cipher, one round per clock.
// The key schedule is expanded forward to round key 10, then unwound in reverse
// alongside the rounds, so no round-key storage is needed.
//
// Ports:
//   sys_clk   - clock, rising edge
//   sys_rst   - synchronous active-high reset
//   in_valid  / in_ready  - job handshake (ctext, key sampled on accept edge)
//   ctext, key - 128-bit inputs, FIPS-197 byte order (byte 0 in [127:120])
//   out_valid / out_ready - result handshake; ptext held until released
//   ptext     - 128-bit plaintext
//   busy      - high whenever the FSM is not idle
//
// Optional: define AES_DEC_KEYCACHE_EN to cache the last key and its round key 10,
// letting a repeated key skip the forward expansion (latency 11 instead of 21).
module aes128_dec_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ctext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ptext,
  output logic         busy
);

  localparam logic [3:0] LastRnd = 4'(NR);

  typedef enum logic [2:0] {StIdle, StExpand, StRound, StFinal, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ptext_q, ptext_d;
  logic         ovalid_q, ovalid_d;
`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk_q, cache_rk_d;
  logic         cache_vld_q, cache_vld_d;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 by square-and-multiply; maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // One inverse round: optional InvMixColumns, then InvShiftRows + InvSubBytes.
  function automatic logic [127:0] inv_round(input logic [127:0] a, input logic first);
    logic [127:0] b;
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      b[127-32*c -: 32] = first ? a[127-32*c -: 32] : inv_mix_col(a[127-32*c -: 32]);
    end
    // Byte (row r, column c) sits at index 4c+r; it takes row r's byte from column c-r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(b[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    unique case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Forward and reverse expansion share one g(): its input is w3 going forward and
  // the recovered previous w3 (w7 ^ w6) going backward.
  logic [31:0]  g_in, g_rot, g_out;
  logic [127:0] rk_fwd, rk_rev;
  logic [31:0]  o0, o1, o2, o3, n4, n5, n6, n7;

  always_comb begin
    g_in  = (state_q == StRound) ? (rk_q[31:0] ^ rk_q[63:32]) : rk_q[31:0];
    g_rot = {g_in[23:0], g_in[31:24]};
    g_out = {sbox(g_rot[31:24]) ^ rcon(cnt_q), sbox(g_rot[23:16]),
             sbox(g_rot[15:8]), sbox(g_rot[7:0])};
    n4 = rk_q[127:96] ^ g_out;
    n5 = rk_q[95:64] ^ n4;
    n6 = rk_q[63:32] ^ n5;
    n7 = rk_q[31:0] ^ n6;
    rk_fwd = {n4, n5, n6, n7};
    o3 = rk_q[31:0] ^ rk_q[63:32];
    o2 = rk_q[63:32] ^ rk_q[95:64];
    o1 = rk_q[95:64] ^ rk_q[127:96];
    o0 = rk_q[127:96] ^ g_out;
    rk_rev = {o0, o1, o2, o3};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    rk_d     = rk_q;
    ptext_d  = ptext_q;
    ovalid_d = ovalid_q;
`ifdef AES_DEC_KEYCACHE_EN
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
    cache_vld_d = cache_vld_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          st_d    = ctext;
          rk_d    = key;
          cnt_d   = 4'd1;
          state_d = StExpand;
`ifdef AES_DEC_KEYCACHE_EN
          if (cache_vld_q && (key == cache_key_q)) begin
            rk_d    = cache_rk_q;
            cnt_d   = LastRnd;
            state_d = StRound;
          end else begin
            // Invalidate until the matching round key 10 is known.
            cache_key_d = key;
            cache_vld_d = 1'b0;
          end
`endif
        end
      end
      StExpand: begin
        rk_d  = rk_fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastRnd) begin
          cnt_d   = LastRnd;
          state_d = StRound;
`ifdef AES_DEC_KEYCACHE_EN
          cache_rk_d  = rk_fwd;
          cache_vld_d = 1'b1;
`endif
        end
      end
      StRound: begin
        st_d  = inv_round(st_q ^ rk_q, cnt_q == LastRnd);
        rk_d  = rk_rev;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StFinal;
      end
      StFinal: begin
        ptext_d  = st_q ^ rk_q;
        ovalid_d = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      st_q     <= '0;
      rk_q     <= '0;
      ptext_q  <= '0;
      ovalid_q <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
      cache_key_q <= '0;
      cache_rk_q  <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      rk_q     <= rk_d;
      ptext_q  <= ptext_d;
      ovalid_q <= ovalid_d;
`ifdef AES_DEC_KEYCACHE_EN
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = ovalid_q;
  assign ptext     = ptext_q;

endmodule

// File: tb/tb_aes128_dec_iter.sv
// Directed bench for aes128_dec_iter using FIPS-197 C.1 and Appendix B vectors.
// Expected latencies follow AES_DEC_KEYCACHE_EN when it is defined.
module tb_aes128_dec_iter;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int FullLat = 21;
`ifdef AES_DEC_KEYCACHE_EN
  localparam int HitLat = 11;
  localparam int RstAt  = 5;
`else
  localparam int HitLat = 21;
  localparam int RstAt  = 15;
`endif

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ctext = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] ptext;
  logic         busy;

  int checks = 0;
  int errors = 0;

  aes128_dec_iter #(.NR(10)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctext     (ctext),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptext     (ptext),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, then presents one job for a single accept edge.
  task automatic start_job(input logic [127:0] c, input logic [127:0] k);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge sys_clk); #1;
      guard++;
    end
    chk("in_ready_before_job", 128'(in_ready), 128'(1'b1));
    ctext = c;
    key = k;
    in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    ctext = ~c;  // later changes must be ignored
    key = ~k;
  endtask

  // Counts edges from the accept edge until out_valid, then checks latency and data.
  task automatic wait_result(input string tag, input logic [127:0] exp, input int lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(lat));
    chk({tag, "_ptext"}, ptext, exp);
  endtask

  initial begin
    int n;
    int seen;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_ptext", ptext, 128'h0);
    chk("reset_busy", 128'(busy), 128'(1'b0));

    // C.1 with backpressure on the result.
    out_ready = 1'b0;
    start_job(CtC1, KeyC1);
    chk("c1_busy", 128'(busy), 128'(1'b1));
    wait_result("c1", PtC1, FullLat);
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk); #1;
      chk("bp_ptext_stable", ptext, PtC1);
      chk("bp_out_valid_held", 128'(out_valid), 128'(1'b1));
      chk("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
    end
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    chk("release_out_valid", 128'(out_valid), 128'(1'b0));
    chk("release_in_ready", 128'(in_ready), 128'(1'b1));

    // Appendix B, then repeated keys (cache hits when the cache is built in).
    start_job(CtB, KeyB);
    wait_result("appb", PtB, FullLat);
    start_job(CtB, KeyB);
    wait_result("appb_repeat", PtB, HitLat);
    start_job(CtC1, KeyC1);
    wait_result("c1_newkey", PtC1, FullLat);
    start_job(CtC1, KeyC1);
    wait_result("c1_repeat", PtC1, HitLat);

    // Reset while ROUND has cnt=5.
    start_job(CtC1, KeyC1);
    repeat (RstAt) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("midrst_ptext", ptext, 128'h0);
    chk("midrst_busy", 128'(busy), 128'(1'b0));
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge sys_clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_output", 128'(seen), 128'(0));
    start_job(CtB, KeyB);
    wait_result("appb_after_rst", PtB, FullLat);

    // Back-to-back with in_valid held and out_ready tied high.
    @(posedge sys_clk); #1;
    ctext = CtC1;
    key = KeyC1;
    in_valid = 1'b1;
    @(posedge sys_clk); #1;
    ctext = CtB;
    key = KeyB;
    wait_result("b2b_first", PtC1, FullLat);
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge sys_clk); #1;
      n++;
    end
    @(posedge sys_clk); #1;
    n++;
    in_valid = 1'b0;
    chk("b2b_second_accept_gap", 128'(n), 128'(2));
    chk("b2b_busy_after_accept", 128'(busy), 128'(1'b1));
    wait_result("b2b_second", PtB, FullLat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
